// File: rtl/aoc1_rot_parser_if.sv
// rtl/aoc1_rot_parser_if.sv - ASCII byte stream handshake into the rotation parser
interface aoc1_rot_parser_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/aoc1_rot_parser.sv
// rtl/aoc1_rot_parser.sv - parses "L68\nR30\n..." into {dir, rotation} records for the dial counter
module aoc1_rot_parser #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  aoc1_rot_parser_if.slave      in_if,
  output logic                  rot_en,
  output logic                  rot_dir,
  output logic [DATA_WIDTH-1:0] rot_val,
  output logic [DATA_WIDTH-1:0] rec_count,
  output logic                  done,
  output logic                  error
);

  localparam int WW = DATA_WIDTH + 4;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    NUM,
    ERR,
    DONE
  } state_t;

  state_t                state;
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] acc;

  logic                  accept;
  logic                  is_digit;
  logic                  is_dir;
  logic                  is_lf;
  logic                  is_cr;
  logic [3:0]            digit;
  logic [WW-1:0]         acc_wide;
  logic                  ovf;
  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_val;

  assign in_if.in_ready = (state != DONE);
  assign accept         = in_if.in_valid && in_if.in_ready;

  assign is_digit = (in_if.in_data >= 8'h30) && (in_if.in_data <= 8'h39);
  assign is_dir   = (in_if.in_data == 8'h4C) || (in_if.in_data == 8'h52);
  assign is_lf    = (in_if.in_data == 8'h0A);
  assign is_cr    = (in_if.in_data == 8'h0D);
  // ASCII '0'..'9' carry their value in the low nibble
  assign digit    = in_if.in_data[3:0];
  assign acc_wide = WW'(acc) * WW'(10) + WW'(digit);
  assign ovf      = |acc_wide[WW-1:DATA_WIDTH];

  // A record is emitted on '\n', or on a digit/CR that closes the file without a newline
  always_comb begin
    emit     = 1'b0;
    emit_val = acc;
    if (accept) begin
      case (state)
        FIRST: begin
          if (is_digit && in_if.in_last) begin
            emit     = 1'b1;
            emit_val = DATA_WIDTH'(digit);
          end
        end
        NUM: begin
          if (is_digit) begin
            if (!ovf && in_if.in_last) begin
              emit     = 1'b1;
              emit_val = acc_wide[DATA_WIDTH-1:0];
            end
          end else if (is_lf || (is_cr && in_if.in_last)) begin
            emit = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      acc       <= '0;
      rot_en    <= 1'b0;
      rot_dir   <= 1'b0;
      rot_val   <= '0;
      rec_count <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rot_en <= emit;
      if (emit) begin
        rot_dir   <= dir_q;
        rot_val   <= emit_val;
        rec_count <= rec_count + DATA_WIDTH'(1);
      end
      if (accept) begin
        case (state)
          IDLE: begin
            if (is_dir) begin
              dir_q <= (in_if.in_data == 8'h4C);
              acc   <= '0;
              state <= FIRST;
              if (in_if.in_last) error <= 1'b1;
            end else if (!(is_lf || is_cr)) begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          FIRST: begin
            if (is_digit) begin
              acc   <= DATA_WIDTH'(digit);
              state <= NUM;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          NUM: begin
            if (is_digit) begin
              if (ovf) begin
                state <= ERR;
                error <= 1'b1;
              end else begin
                acc <= acc_wide[DATA_WIDTH-1:0];
              end
            end else if (is_lf) begin
              state <= IDLE;
            end else if (!is_cr) begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
        // Every accepted final byte terminates parsing, whatever state it arrived in
        if (in_if.in_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aoc1_rot_parser.sv
// tb/tb_aoc1_rot_parser.sv - directed-vector bench for aoc1_rot_parser
module tb_aoc1_rot_parser;

  logic        clock = 1'b0;
  logic        reset;
  logic        rot_en;
  logic        rot_dir;
  logic [15:0] rot_val;
  logic [15:0] rec_count;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [16:0] recs[$];

  aoc1_rot_parser_if bus ();

  aoc1_rot_parser #(.DATA_WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_if     (bus.slave),
    .rot_en    (rot_en),
    .rot_dir   (rot_dir),
    .rot_val   (rot_val),
    .rec_count (rec_count),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (rot_en) recs.push_back({rot_dir, rot_val});
  end

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    recs.delete();
  endtask

  task automatic send(input string s, input bit with_last, input bit throttle);
    for (int i = 0; i < s.len(); i++) begin
      if (throttle) begin
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h4C;
        bus.in_last  = 1'b1;
      end
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      bus.in_last  = with_last && (i == s.len() - 1);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rot_en, rot_dir, rot_val, rec_count, done, error} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b dir=%0b val=%0d cnt=%0d done=%0b err=%0b, want all 0",
               rot_en, rot_dir, rot_val, rec_count, done, error);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [16:0] exp[3];
    exp[0] = {1'b1, 16'd68};
    exp[1] = {1'b1, 16'd30};
    exp[2] = {1'b0, 16'd48};
    do_reset();
    send("L68\nL30\nR48\n", 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (recs.size() !== 3) begin
      errors++;
      $display("FAIL basic_nrec: got %0d want 3", recs.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (recs.size() <= i || recs[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_rec%0d: got %h want %h", i, (recs.size() > i) ? recs[i] : 17'h1ffff, exp[i]);
      end
    end
    checks++;
    if ({rec_count, done, error, bus.in_ready} !== {16'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_status: got cnt=%0d done=%0b err=%0b rdy=%0b want 3 1 0 0",
               rec_count, done, error, bus.in_ready);
    end
    checks++;
    if ({rot_en, rot_dir, rot_val} !== {1'b0, 1'b0, 16'd48}) begin
      errors++;
      $display("FAIL basic_hold: got en=%0b dir=%0b val=%0d want 0 0 48", rot_en, rot_dir, rot_val);
    end
  endtask

  task automatic test_crlf_throttle();
    do_reset();
    send("R1000\r\n\r\nL5\r\n", 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    checks++;
    if (recs.size() !== 2) begin
      errors++;
      $display("FAIL crlf_nrec: got %0d want 2", recs.size());
    end
    checks++;
    if (recs.size() < 2 || recs[0] !== {1'b0, 16'd1000} || recs[1] !== {1'b1, 16'd5}) begin
      errors++;
      $display("FAIL crlf_recs: got %0d records, first=%h want 03e8 then 10005", recs.size(),
               (recs.size() > 0) ? recs[0] : 17'h1ffff);
    end
    checks++;
    if ({rec_count, done, error} !== {16'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL crlf_status: got cnt=%0d done=%0b err=%0b want 2 1 0", rec_count, done, error);
    end
  endtask

  task automatic test_no_newline();
    do_reset();
    send("L99\nR250", 1'b1, 1'b0);
    checks++;
    if ({done, rot_en, rot_dir, rot_val} !== {1'b1, 1'b1, 1'b0, 16'd250}) begin
      errors++;
      $display("FAIL nonl_final: got done=%0b en=%0b dir=%0b val=%0d want 1 1 0 250",
               done, rot_en, rot_dir, rot_val);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (recs.size() !== 2 || recs[0] !== {1'b1, 16'd99} || rec_count !== 16'd2 || error !== 1'b0) begin
      errors++;
      $display("FAIL nonl_recs: got n=%0d cnt=%0d err=%0b want 2 records (1,99),(0,250) cnt=2 err=0",
               recs.size(), rec_count, error);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send("R65535\nR65536\nL1\n", 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (recs.size() !== 1 || recs[0] !== {1'b0, 16'd65535}) begin
      errors++;
      $display("FAIL ovf_recs: got n=%0d first=%h want 1 record 0ffff", recs.size(),
               (recs.size() > 0) ? recs[0] : 17'h1ffff);
    end
    checks++;
    if ({rec_count, done, error} !== {16'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_status: got cnt=%0d done=%0b err=%0b want 1 1 1", rec_count, done, error);
    end
  endtask

  task automatic test_malformed();
    string bad[2];
    bad[0] = "X5\n";
    bad[1] = "L\n";
    for (int i = 0; i < 2; i++) begin
      do_reset();
      send(bad[i], 1'b1, 1'b0);
      repeat (2) @(negedge clock);
      checks++;
      if ({error, done, rec_count} !== {1'b1, 1'b1, 16'd0} || recs.size() !== 0) begin
        errors++;
        $display("FAIL malformed%0d: got err=%0b done=%0b cnt=%0d nrec=%0d want 1 1 0 0",
                 i, error, done, rec_count, recs.size());
      end
    end
    do_reset();
    send("L1", 1'b0, 1'b0);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL space_before: got err=%0b want 0", error);
    end
    send(" ", 1'b0, 1'b0);
    checks++;
    if ({error, done} !== 2'b10) begin
      errors++;
      $display("FAIL space_at: got err=%0b done=%0b want 1 0", error, done);
    end
    send("2\n", 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if ({error, done, rec_count} !== {1'b1, 1'b1, 16'd0} || recs.size() !== 0) begin
      errors++;
      $display("FAIL space_end: got err=%0b done=%0b cnt=%0d nrec=%0d want 1 1 0 0",
               error, done, rec_count, recs.size());
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    send("L12", 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (recs.size() !== 0 || rec_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_stale: got nrec=%0d cnt=%0d want 0 0", recs.size(), rec_count);
    end
    send("R3\n", 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (recs.size() !== 1 || recs[0] !== {1'b0, 16'd3} || rec_count !== 16'd1 || error !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rec: got nrec=%0d cnt=%0d err=%0b want one record (0,3) cnt=1 err=0",
               recs.size(), rec_count, error);
    end
  endtask

  task automatic test_leading_zeros();
    do_reset();
    send("R007\nL0\n", 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (recs.size() !== 2 || recs[0] !== {1'b0, 16'd7} || recs[1] !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL zeros_recs: got nrec=%0d first=%h want (0,7),(1,0)", recs.size(),
               (recs.size() > 0) ? recs[0] : 17'h1ffff);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    test_reset();
    test_basic();
    test_crlf_throttle();
    test_no_newline();
    test_overflow();
    test_malformed();
    test_reset_midline();
    test_leading_zeros();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
